control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Hardwired control unit that drives the datapath's control inputs (PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, register-select strobes, ALU op lines).
- Replaces hand-sequenced stimulus with a fetch/decode/execute FSM that reads IR fields.
- Covers register-register ALU/shift/rotate instructions plus nop and halt.
- Sits between the memory handshake and the datapath.

Parameters:
- OPW, 5, opcode width, IR[31:27].

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous active-low reset.
- Start  in  1  level; leaves IDLE/HALT and begins fetch.
- Stop  in  1  request to stop at the next instruction boundary.
- IR  in  32  instruction register contents from the datapath; Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
- Mem_ack  in  1  memory read complete.
- PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read  out  1 each  datapath strobes.
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-field select and register in/out enables.
- Op_sel  out  11  one-hot ALU op, bit order: ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT.
- Run  out  1  high while executing.
- Illegal  out  1  sticky illegal-opcode flag (feature only).

Behaviour:
- Clock is `Clock`. Reset is asynchronous and active-low on `Resetn`. Reset forces state IDLE and drives every output to 0 immediately, including mid-instruction.
- All outputs are Moore: decoded from the registered state and the registered opcode class. No combinational path from Start, Stop or Mem_ack to any output.
- Opcode map (IR[31:27]):
  - 00011 add, 00100 sub, 00101 and, 00110 or.
  - 00111 shr, 01000 shra, 01001 shl, 01010 ror, 01011 rol.
  - 10001 neg, 10010 not (unary).
  - 11010 nop, 11011 halt.
  - All others are illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, HALT.
- IDLE/HALT: all strobes 0. Start=1 moves to T0 on the next edge.
- T0: PCout, MARin, IncPC, Zin. Next state T1.
- T1: Zlowout, PCin, Read, MDRin held every cycle until Mem_ack is sampled 1, then T2. Unbounded wait. Mem_ack in any other state is ignored.
- T2: MDRout, IRin. The opcode is latched from IR at the T2→T3 edge, so it is stable for T3–T5.
- Binary ops:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Op_sel bit, Zin.
  - T5: Zlowout, Gra, Rin.
- Unary ops:
  - T3: Grb, Rout, Op_sel bit, Zin.
  - T4: Zlowout, Gra, Rin.
  - Skip T5.
- nop: T3 asserts nothing and ends the instruction.
- halt: T3 moves to HALT with Run=0.
- Instruction boundary = leaving T5 (binary), T4 (unary) or T3 (nop).
- At a boundary: Stop=1 → IDLE; otherwise → T0. Start and Stop both high at a boundary: Stop wins.
- Run=1 in T0–T5, 0 in IDLE/HALT.
- Latency: binary 6 cycles + (Mem_ack wait cycles); unary 5 + wait; nop 4 + wait.
- Op_sel has exactly one bit set in the execute cycle only; otherwise 0.

Optional Feature:
- ILLEGAL_OP_TRAP_EN
- Defined: an illegal opcode at T3 goes to HALT and sets Illegal=1. Illegal is cleared only by reset.
- Undefined: an illegal opcode executes as nop, and the Illegal port is tied to 0.

Test Plan:
- Reset, Start=1, Mem_ack=1 always, IR=32'h28918000 (and R1,R2,R3):
  - T0 through T5 occur on consecutive edges.
  - T3 has Grb+Rout+Yin; T4 has Grc+Rout+Op_sel=11'b00000000100+Zin; T5 has Zlowout+Gra+Rin.
  - Then T0 again with Run=1.
- Shr (IR[31:27]=00111) with Mem_ack low for 3 cycles in T1: Read and MDRin stay high 4 cycles, Op_sel bit SHR appears in T4, total 9 cycles.
- Neg (10001): Op_sel NEG with Zin in T3; Gra+Rin in T4; the next cycle is T0 (no T5).
- Halt opcode: T3 → HALT, Run=0, all strobes 0. A later Start=1 restarts fetch at T0.
- Stop=1 asserted during T4 of an add: completes T5, then IDLE. Resetn=0 pulsed during T1: every output is 0 before the next edge, and the block returns to IDLE.
- With ILLEGAL_OP_TRAP_EN, IR opcode 11111: HALT and Illegal=1. Without it: behaves as nop, returns to T0, Illegal=0.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control unit for the register-register datapath
// Ports:
//   Clock, Resetn (async, active-low)   clock and reset
//   Start, Stop                         leave IDLE/HALT; stop at next instruction boundary
//   IR[31:0]                            instruction register, opcode in IR[31:27]
//   Mem_ack                             memory read complete (only honoured in T1)
//   PCout..Read, Gra..Rout              registered datapath strobes
//   Op_sel[10:0]                        one-hot ALU op {NOT,NEG,ROL,ROR,SHL,SHRA,SHR,OR,AND,SUB,ADD}
//   Run                                 high in T0..T5
//   Illegal                             sticky illegal-opcode flag
// Macro ILLEGAL_OP_TRAP_EN: illegal opcodes trap to HALT and set Illegal; otherwise they act as nop.
module control_sequencer #(
    parameter int OPW = 5
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Start,
    input  logic        Stop,
    input  logic [31:0] IR,
    input  logic        Mem_ack,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [10:0] Op_sel,
    output logic        Run,
    output logic        Illegal
);
`ifdef ILLEGAL_OP_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, HALT} state_t;
    typedef enum logic [2:0] {K_NOP, K_BIN, K_UN, K_HALT, K_ILL} kind_t;
    state_t state, state_nx, bnd;
    kind_t kind, kind_nx, dec_kind;
    logic [10:0] op, op_nx, dec_op, op_sel_nx;
    logic [OPW-1:0] opc;
    logic [15:0] strb_nx;
    logic t0, t1, t2, t3, t4, t5, bin, un, run_nx, ill_nx;
    logic unused_ir;
    assign opc = IR[31 -: OPW];
    assign unused_ir = ^IR[31-OPW:0];
    always_comb begin
        dec_kind = (opc >= OPW'(3) && opc <= OPW'(11)) ? K_BIN :
                   (opc == OPW'(17) || opc == OPW'(18)) ? K_UN :
                   (opc == OPW'(26)) ? K_NOP :
                   (opc == OPW'(27)) ? K_HALT : K_ILL;
        dec_op = (dec_kind == K_BIN) ? 11'(1) << (opc - OPW'(3)) :
                 (opc == OPW'(17)) ? 11'h200 :
                 (opc == OPW'(18)) ? 11'h400 : 11'h000;
        bnd = Stop ? IDLE : T0;
        kind_nx = (state == T2) ? dec_kind : kind;
        op_nx = (state == T2) ? dec_op : op;
        state_nx = state;
        case (state)
            IDLE, HALT: state_nx = Start ? T0 : state;
            T0: state_nx = T1;
            T1: state_nx = Mem_ack ? T2 : T1;
            T2: state_nx = T3;
            T3: state_nx = (kind == K_BIN || kind == K_UN) ? T4 :
                           (kind == K_HALT || (TRAP && kind == K_ILL)) ? HALT : bnd;
            T4: state_nx = (kind == K_BIN) ? T5 : bnd;
            default: state_nx = bnd;
        endcase
        // Outputs are registered, so they are decoded from the state being entered.
        t0 = state_nx == T0;
        t1 = state_nx == T1;
        t2 = state_nx == T2;
        t3 = state_nx == T3;
        t4 = state_nx == T4;
        t5 = state_nx == T5;
        bin = kind_nx == K_BIN;
        un = kind_nx == K_UN;
        strb_nx = {t0, t1 || t5 || (t4 && un), t2, t0, t0 || (t4 && bin) || (t3 && un),
                   t1, t1, t2, t3 && bin, t0, t1,
                   t5 || (t4 && un), t3 && (bin || un), t4 && bin,
                   t5 || (t4 && un), (t3 && (bin || un)) || (t4 && bin)};
        op_sel_nx = ((t4 && bin) || (t3 && un)) ? op_nx : 11'h000;
        run_nx = state_nx != IDLE && state_nx != HALT;
        ill_nx = Illegal || (TRAP && state == T3 && kind == K_ILL);
    end
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
            kind <= K_NOP;
            op <= 11'h000;
            {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
             Gra, Grb, Grc, Rin, Rout} <= 16'h0000;
            Op_sel <= 11'h000;
            Run <= 1'b0;
            Illegal <= 1'b0;
        end else begin
            state <= state_nx;
            kind <= kind_nx;
            op <= op_nx;
            {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
             Gra, Grb, Grc, Rin, Rout} <= strb_nx;
            Op_sel <= op_sel_nx;
            Run <= run_nx;
            Illegal <= ill_nx;
        end
    end
endmodule
